// File: rtl/router_pkg.sv
// Shared types and helpers for the 1xN router control path.
// State encoding, channel limits and a constant clog2.
package router_pkg;

    localparam int MIN_CH = 2;
    localparam int MAX_CH = 16;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        CHECK_PARITY_ERROR = 4'd4,
        FIFO_FULL_STATE    = 4'd5,
        LOAD_AFTER_FULL    = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PKT           = 4'd8
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/router_fsm_nch_timer.sv
// Bounded wait counter for the WAIT_TILL_EMPTY state.
// Saturates instead of wrapping; never expires when WAIT_TIMEOUT is 0.
module router_wait_timer
    import router_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 256
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int RAW_W = clog2(WAIT_TIMEOUT + 1);
    localparam int TW    = (RAW_W < 1) ? 1 : RAW_W;

    logic [TW-1:0] count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TW'(1);
        end
    end

    generate
        if (WAIT_TIMEOUT == 0) begin : g_forever
            assign expire = 1'b0;
        end else begin : g_bounded
            assign expire = (count == TW'(WAIT_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/router_fsm_nch.sv
// Control FSM for a 1xN packet router: decode, load, parity, stall,
// illegal-address drop and bounded wait-till-empty with timeout drop.
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 256
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic [NUM_CH-1:0] fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic [ADDR_W-1:0] dest_sel,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              drop_state,
    output logic              addr_err,
    output logic              wait_timeout
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] sel;
    logic              sel_empty;
    logic              sel_full;
    logic              soft_hit;
    logic              illegal;
    logic              expire;
    logic              addr_err_d;
    logic              timeout_d;
    logic              in_wait;

    // In DECODE the header is not latched yet, so look at data_in directly.
    always_comb begin
        sel       = (state == DECODE_ADDRESS) ? data_in : dest_sel;
        sel_empty = 1'b0;
        sel_full  = 1'b0;
        soft_hit  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == ADDR_W'(i)) begin
                sel_empty = fifo_empty[i];
                sel_full  = fifo_full[i];
            end
            if (dest_sel == ADDR_W'(i)) begin
                soft_hit = soft_reset[i];
            end
        end
    end

    assign illegal = (32'(data_in) >= 32'(NUM_CH));
    assign in_wait = (state == WAIT_TILL_EMPTY);

    router_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_timer (
        .clock (clock),
        .resetn(resetn),
        .enable(in_wait),
        .clear (!in_wait),
        .expire(expire)
    );

    always_comb begin
        next_state = state;
        addr_err_d = 1'b0;
        timeout_d  = 1'b0;
        unique case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (illegal) begin
                        next_state = DROP_PKT;
                        addr_err_d = 1'b1;
                    end else if (sel_empty) begin
                        next_state = LOAD_FIRST_DATA;
                    end else begin
                        next_state = WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (sel_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = sel_full ? FIFO_FULL_STATE
                                      : DECODE_ADDRESS;
            end
            FIFO_FULL_STATE: begin
                if (!sel_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) begin
                    next_state = LOAD_FIRST_DATA;
                end else if (expire) begin
                    next_state = DROP_PKT;
                    timeout_d  = 1'b1;
                end
            end
            DROP_PKT: begin
                if (!pkt_valid) begin
                    next_state = DECODE_ADDRESS;
                end
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        // Only the channel this packet targets may abort it.
        if ((state != DECODE_ADDRESS) && soft_hit) begin
            next_state = DECODE_ADDRESS;
            timeout_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= DECODE_ADDRESS;
            dest_sel     <= '0;
            addr_err     <= 1'b0;
            wait_timeout <= 1'b0;
        end else begin
            state        <= next_state;
            addr_err     <= addr_err_d;
            wait_timeout <= timeout_d;
            if ((state == DECODE_ADDRESS) && pkt_valid) begin
                dest_sel <= data_in;
            end
        end
    end

    assign detect_add  = (state == DECODE_ADDRESS);
    assign lfd_state   = (state == LOAD_FIRST_DATA);
    assign ld_state    = (state == LOAD_DATA);
    assign laf_state   = (state == LOAD_AFTER_FULL);
    assign full_state  = (state == FIFO_FULL_STATE);
    assign rst_int_reg = (state == CHECK_PARITY_ERROR);
    assign drop_state  = (state == DROP_PKT);

    assign write_enb_reg = (state == LOAD_DATA)
                         | (state == LOAD_PARITY)
                         | (state == LOAD_AFTER_FULL);

    assign busy = (state == LOAD_FIRST_DATA)
                | (state == LOAD_PARITY)
                | (state == FIFO_FULL_STATE)
                | (state == LOAD_AFTER_FULL)
                | (state == CHECK_PARITY_ERROR)
                | (state == WAIT_TILL_EMPTY);

endmodule

// File: tb/tb_router_fsm_nch.sv
// Bench for router_fsm_nch: directed scenarios plus random traffic
// against a packet-level reference model, for two timeout settings.
module tb_router_fsm_nch;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;

    logic [1:0] dest_a, dest_b;
    logic busy_a, da_a, lfd_a, ld_a, laf_a, full_a, rst_a;
    logic web_a, drop_a, ae_a, wt_a;
    logic busy_b, da_b, lfd_b, ld_b, laf_b, full_b, rst_b;
    logic web_b, drop_b, ae_b, wt_b;

    int checks;
    int errors;

    // {busy,detect,lfd,ld,laf,full,rst_int,write_enb,drop}
    localparam logic [8:0] V_DEC  = 9'b010000000;
    localparam logic [8:0] V_LFD  = 9'b101000000;
    localparam logic [8:0] V_LD   = 9'b000100010;
    localparam logic [8:0] V_LP   = 9'b100000010;
    localparam logic [8:0] V_CPE  = 9'b100000100;
    localparam logic [8:0] V_FULL = 9'b100001000;
    localparam logic [8:0] V_LAF  = 9'b100010010;
    localparam logic [8:0] V_WAIT = 9'b100000000;
    localparam logic [8:0] V_DROP = 9'b000000001;

    router_fsm_nch #(
        .NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(256)
    ) dut_a (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
        .data_in(data_in), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .dest_sel(dest_a), .busy(busy_a), .detect_add(da_a),
        .lfd_state(lfd_a), .ld_state(ld_a), .laf_state(laf_a),
        .full_state(full_a), .rst_int_reg(rst_a),
        .write_enb_reg(web_a), .drop_state(drop_a),
        .addr_err(ae_a), .wait_timeout(wt_a)
    );

    router_fsm_nch #(
        .NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(4)
    ) dut_b (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
        .data_in(data_in), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .dest_sel(dest_b), .busy(busy_b), .detect_add(da_b),
        .lfd_state(lfd_b), .ld_state(ld_b), .laf_state(laf_b),
        .full_state(full_b), .rst_int_reg(rst_b),
        .write_enb_reg(web_b), .drop_state(drop_b),
        .addr_err(ae_b), .wait_timeout(wt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: packet phases, one per DUT timeout setting.
    typedef enum {
        M_DEC, M_LFD, M_LD, M_LP, M_CPE, M_FULL, M_LAF, M_WAIT, M_DROP
    } mph_t;

    mph_t       m_ph  [2];
    logic [1:0] m_dest[2];
    int         m_wait[2];
    logic       m_ae  [2];
    logic       m_wt  [2];
    int         lim   [2] = '{256, 4};

    function automatic logic [12:0] obs(input int k);
        if (k == 0) begin
            return {dest_a, busy_a, da_a, lfd_a, ld_a, laf_a,
                    full_a, rst_a, web_a, drop_a, ae_a, wt_a};
        end
        return {dest_b, busy_b, da_b, lfd_b, ld_b, laf_b,
                full_b, rst_b, web_b, drop_b, ae_b, wt_b};
    endfunction

    function automatic logic [12:0] expv(input int k);
        logic [8:0] v;
        case (m_ph[k])
            M_DEC:   v = V_DEC;
            M_LFD:   v = V_LFD;
            M_LD:    v = V_LD;
            M_LP:    v = V_LP;
            M_CPE:   v = V_CPE;
            M_FULL:  v = V_FULL;
            M_LAF:   v = V_LAF;
            M_WAIT:  v = V_WAIT;
            default: v = V_DROP;
        endcase
        return {m_dest[k], v, m_ae[k], m_wt[k]};
    endfunction

    task automatic tick();
        mph_t       n_ph  [2];
        logic [1:0] n_dest[2];
        int         n_wait[2];
        logic       n_ae  [2];
        logic       n_wt  [2];
        for (int k = 0; k < 2; k++) begin
            int   ch;
            logic emp;
            logic ful;
            n_ph[k]   = m_ph[k];
            n_dest[k] = m_dest[k];
            n_ae[k]   = 1'b0;
            n_wt[k]   = 1'b0;
            n_wait[k] = (m_ph[k] == M_WAIT) ? m_wait[k] + 1 : 0;
            ch  = (m_ph[k] == M_DEC) ? int'(data_in) : int'(m_dest[k]);
            emp = (ch < 3) ? fifo_empty[ch] : 1'b0;
            ful = (ch < 3) ? fifo_full[ch] : 1'b0;
            if (m_ph[k] == M_DEC && pkt_valid) n_dest[k] = data_in;
            case (m_ph[k])
                M_DEC: if (pkt_valid) begin
                    if (data_in >= 2'd3) begin
                        n_ph[k] = M_DROP;
                        n_ae[k] = 1'b1;
                    end else begin
                        n_ph[k] = emp ? M_LFD : M_WAIT;
                    end
                end
                M_LFD:  n_ph[k] = M_LD;
                M_LD:   n_ph[k] = ful ? M_FULL
                                : (!pkt_valid ? M_LP : M_LD);
                M_LP:   n_ph[k] = M_CPE;
                M_CPE:  n_ph[k] = ful ? M_FULL : M_DEC;
                M_FULL: n_ph[k] = ful ? M_FULL : M_LAF;
                M_LAF:  n_ph[k] = parity_done ? M_DEC
                                : (low_pkt_valid ? M_LP : M_LD);
                M_WAIT: begin
                    if (emp) begin
                        n_ph[k] = M_LFD;
                    end else if (lim[k] != 0 &&
                                 m_wait[k] == lim[k] - 1) begin
                        n_ph[k] = M_DROP;
                        n_wt[k] = 1'b1;
                    end
                end
                default: if (!pkt_valid) n_ph[k] = M_DEC;
            endcase
            if (m_ph[k] != M_DEC && m_dest[k] < 2'd3 &&
                soft_reset[m_dest[k]]) begin
                n_ph[k] = M_DEC;
                n_wt[k] = 1'b0;
            end
            if (!resetn) begin
                n_ph[k]   = M_DEC;
                n_dest[k] = 2'd0;
                n_wait[k] = 0;
                n_ae[k]   = 1'b0;
                n_wt[k]   = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_ph[k]   = n_ph[k];
            m_dest[k] = n_dest[k];
            m_wait[k] = n_wait[k];
            m_ae[k]   = n_ae[k];
            m_wt[k]   = n_wt[k];
        end
    endtask

    task automatic clear_inputs();
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        fifo_full     = 3'b000;
        fifo_empty    = 3'b111;
        soft_reset    = 3'b000;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] want;
        do_reset();
        want = {2'd0, V_DEC, 2'b00};
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== want) begin
                errors++;
                $display("FAIL reset dut%0d got %b want %b",
                         k, obs(k), want);
            end
        end
    endtask

    task automatic test_basic();
        logic [8:0] seq [8];
        int web_cnt;
        seq = '{V_LFD, V_LD, V_LD, V_LD, V_LD, V_LP, V_CPE, V_DEC};
        web_cnt = 0;
        do_reset();
        fifo_empty = 3'b111;
        pkt_valid  = 1'b1;
        data_in    = 2'd2;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) pkt_valid = 1'b0;
            tick();
            if (web_a) web_cnt++;
            checks++;
            if (obs(0)[10:2] !== seq[i]) begin
                errors++;
                $display("FAIL basic step %0d got %b want %b",
                         i, obs(0)[10:2], seq[i]);
            end
        end
        checks++;
        if (web_cnt !== 5) begin
            errors++;
            $display("FAIL basic write count got %0d want 5", web_cnt);
        end
        checks++;
        if (dest_a !== 2'd2) begin
            errors++;
            $display("FAIL basic dest got %0d want 2", dest_a);
        end
    endtask

    task automatic drain(input string name);
        int n;
        pkt_valid = 1'b0;
        fifo_full = 3'b000;
        n = 0;
        while (!da_a && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!da_a) begin
            errors++;
            $display("FAIL %s drain got busy=%b want detect_add=1",
                     name, busy_a);
        end
    endtask

    task automatic test_wait();
        do_reset();
        fifo_empty = 3'b101;
        pkt_valid  = 1'b1;
        data_in    = 2'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs(0)[10:2] !== V_WAIT) begin
                errors++;
                $display("FAIL wait cycle %0d got %b want %b",
                         i, obs(0)[10:2], V_WAIT);
            end
        end
        fifo_empty = 3'b111;
        tick();
        checks++;
        if (obs(0)[12:2] !== {2'd1, V_LFD}) begin
            errors++;
            $display("FAIL wait exit got %b want %b",
                     obs(0)[12:2], {2'd1, V_LFD});
        end
        drain("wait");
    endtask

    task automatic test_timeout();
        do_reset();
        fifo_empty = 3'b101;
        pkt_valid  = 1'b1;
        data_in    = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs(1)[10:0] !== {V_WAIT, 2'b00}) begin
                errors++;
                $display("FAIL timeout wait %0d got %b want %b",
                         i, obs(1)[10:0], {V_WAIT, 2'b00});
            end
        end
        tick();
        checks++;
        if (obs(1)[10:0] !== {V_DROP, 2'b01}) begin
            errors++;
            $display("FAIL timeout pulse got %b want %b",
                     obs(1)[10:0], {V_DROP, 2'b01});
        end
        tick();
        checks++;
        if (obs(1)[10:0] !== {V_DROP, 2'b00}) begin
            errors++;
            $display("FAIL timeout hold got %b want %b",
                     obs(1)[10:0], {V_DROP, 2'b00});
        end
        pkt_valid = 1'b0;
        tick();
        checks++;
        if (obs(1)[10:0] !== {V_DEC, 2'b00}) begin
            errors++;
            $display("FAIL timeout exit got %b want %b",
                     obs(1)[10:0], {V_DEC, 2'b00});
        end
    endtask

    task automatic test_addr_err();
        logic [12:0] want [3];
        want = '{{2'd3, V_DROP, 2'b10},
                 {2'd3, V_DROP, 2'b00},
                 {2'd3, V_DEC, 2'b00}};
        do_reset();
        pkt_valid = 1'b1;
        data_in   = 2'd3;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) pkt_valid = 1'b0;
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== want[i]) begin
                    errors++;
                    $display("FAIL addr_err dut%0d step %0d got %b want %b",
                             k, i, obs(k), want[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [8:0] seq [15];
        logic [2:0] ful [15];
        logic       pv  [15];
        logic       low [15];
        logic       pd  [15];
        seq = '{V_LFD, V_LD, V_FULL, V_FULL, V_FULL, V_LAF, V_LP,
                V_CPE, V_DEC, V_LFD, V_LD, V_FULL, V_LAF, V_DEC, V_DEC};
        ful = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        pv  = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        low = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        pd  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        do_reset();
        data_in = 2'd0;
        for (int i = 0; i < 15; i++) begin
            fifo_full     = ful[i];
            pkt_valid     = pv[i];
            low_pkt_valid = low[i];
            parity_done   = pd[i];
            tick();
            checks++;
            if (obs(0)[10:2] !== seq[i]) begin
                errors++;
                $display("FAIL full step %0d got %b want %b",
                         i, obs(0)[10:2], seq[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_soft_reset();
        do_reset();
        pkt_valid = 1'b1;
        data_in   = 2'd2;
        tick();
        tick();
        soft_reset = 3'b001;
        tick();
        checks++;
        if (obs(0)[10:2] !== V_LD) begin
            errors++;
            $display("FAIL soft other got %b want %b",
                     obs(0)[10:2], V_LD);
        end
        soft_reset = 3'b100;
        tick();
        checks++;
        if (obs(0)[10:2] !== V_DEC) begin
            errors++;
            $display("FAIL soft dest got %b want %b",
                     obs(0)[10:2], V_DEC);
        end
        soft_reset = 3'b000;
        data_in    = 2'd1;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (obs(0)[12:2] !== {2'd0, V_DEC}) begin
            errors++;
            $display("FAIL hard reset mid-packet got %b want %b",
                     obs(0)[12:2], {2'd0, V_DEC});
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            resetn        = ($urandom_range(0, 199) != 0);
            pkt_valid     = ($urandom_range(0, 9) < 7);
            data_in       = 2'($urandom_range(0, 3));
            fifo_empty    = 3'($urandom);
            fifo_full     = ($urandom_range(0, 3) == 0) ?
                            3'($urandom) : 3'b000;
            soft_reset    = ($urandom_range(0, 19) == 0) ?
                            3'($urandom) : 3'b000;
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d got %b want %b",
                             k, n, obs(k), expv(k));
                end
            end
        end
        resetn = 1'b1;
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            m_ph[k]   = M_DEC;
            m_dest[k] = 2'd0;
            m_wait[k] = 0;
            m_ae[k]   = 1'b0;
            m_wt[k]   = 1'b0;
        end
        test_reset();
        test_basic();
        test_wait();
        test_timeout();
        test_addr_err();
        test_full();
        test_soft_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
